sw_debouncer: RTL
=================

SW_DEBOUNCER -- requirements
Module: sw_debouncer

Interface
REQ-001 SHALL have parameter WIDTH, default 32: number of switch bits.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth, legal range 2..4.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive cycles required to accept a new level, minimum 1.
REQ-004 SHALL have port i_clk, input, 1: single clock; all state on rising edge.
REQ-005 SHALL have port i_reset, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port i_io_sw, input, WIDTH: raw asynchronous switch levels, as driven by the bench driver.
REQ-007 SHALL have port i_chg_clr, input, 1: single-cycle pulse that clears all sticky change bits.
REQ-008 SHALL have port o_sw_stable, output, WIDTH: debounced switch value presented to the LSU input-peripheral region.
REQ-009 SHALL have port o_chg_mask, output, WIDTH: sticky per-bit flag, set when that bit's stable value toggles.
REQ-010 SHALL have port o_chg_any, output, 1: registered OR of o_chg_mask.

Function
REQ-011 SHALL pass each bit independently through SYNC_STAGES flops before any other use.
REQ-012 SHALL keep a per-bit counter of width $clog2(DEBOUNCE_CYCLES+1); the counter saturates and never wraps.
REQ-013 SHALL clear a bit's counter on any cycle where its synchronized value equals o_sw_stable.
REQ-014 SHALL increment the counter on any cycle where the two differ.
REQ-015 When a differing counter equals DEBOUNCE_CYCLES-1, SHALL load the synchronized value into o_sw_stable, clear the counter, and set the bit in o_chg_mask, all on the same edge.
REQ-016 Latency: a clean input change sampled at edge 1 SHALL appear on o_sw_stable at edge SYNC_STAGES+DEBOUNCE_CYCLES, exactly.
REQ-017 A glitch that returns to the stable level before the count completes SHALL reset the counter and SHALL leave o_sw_stable and o_chg_mask unchanged.
REQ-018 i_chg_clr SHALL clear all o_chg_mask bits on the next edge.
REQ-019 If i_chg_clr coincides with a new toggle on a bit, that bit SHALL remain set; the new event wins.
REQ-020 o_chg_any SHALL lag o_chg_mask by one cycle.
REQ-021 Multiple bits changing in the same cycle SHALL be debounced independently and may update on the same edge.

Reset
REQ-022 While i_reset=0, synchronizer flops, counters, o_sw_stable, o_chg_mask and o_chg_any SHALL be 0 immediately, without waiting for a clock edge.
REQ-023 Reset asserted mid-count SHALL discard the partial count; after release, a held nonzero input SHALL take the full SYNC_STAGES+DEBOUNCE_CYCLES latency and SHALL set o_chg_mask.

Configuration
REQ-024 Macro SW_DEBOUNCE_EN SHALL select debounce behaviour: defined means full debounce per REQ-012..REQ-017.
REQ-025 With SW_DEBOUNCE_EN undefined, o_sw_stable SHALL equal the synchronizer output registered once (latency SYNC_STAGES+1), counters SHALL NOT be instantiated, and change-mask behaviour SHALL be unchanged.

Structure
REQ-026 Shared package sw_pkg SHALL hold SW_WIDTH=32, SW_SYNC_STAGES=2, SW_DEBOUNCE_CYCLES=16, and a typedef for the switch word.
REQ-027 Per-bit logic (synchronizer, counter, stable flop, toggle pulse) SHALL be sub-module sw_debounce_bit, generated WIDTH times.
REQ-028 The top SHALL own o_chg_mask, clear handling and o_chg_any.

Verification (WIDTH=32, SYNC_STAGES=2, DEBOUNCE_CYCLES=4)
REQ-029 Reset, then hold i_io_sw=0x0000_00A5 from edge 1 -> o_sw_stable=0x0000_00A5 at edge 6, o_chg_mask=0x0000_00A5, o_chg_any=1 at edge 7.
REQ-030 Bit 3 pulses high for 3 cycles, then low -> o_sw_stable[3] stays 0 and o_chg_mask[3] stays 0.
REQ-031 Stable 0x1, pulse i_chg_clr on the same edge bit 1 accepts -> o_chg_mask=0x2 (bit 0 cleared, bit 1 kept).
REQ-032 Hold 0xFFFF_FFFF, assert i_reset=0 after 3 cycles, release, keep holding -> outputs 0 during reset; 0xFFFF_FFFF exactly 6 edges after release.
REQ-033 With SW_DEBOUNCE_EN undefined, hold 0x0000_0010 from edge 1 -> o_sw_stable=0x0000_0010 at edge 3, and single-cycle glitches pass through.

Source files
------------

// File: rtl/sw_pkg.sv
// Shared switch-debouncer constants and the switch word type.
package sw_pkg;

  localparam int unsigned SW_WIDTH           = 32;
  localparam int unsigned SW_SYNC_STAGES     = 2;
  localparam int unsigned SW_DEBOUNCE_CYCLES = 16;

  typedef logic [SW_WIDTH-1:0] sw_word_t;

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: synchronizer, optional debounce counter, stable flop and toggle pulse.
// Debounce counter exists only when SW_DEBOUNCE_EN is defined; otherwise the stable flop is a plain register.
module sw_debounce_bit
  import sw_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = SW_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_sw,
  output logic o_stable,
  output logic o_toggle
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || DEBOUNCE_CYCLES < 1) begin : g_bad_param
    $error("sw_debounce_bit: SYNC_STAGES must be 2..4 and DEBOUNCE_CYCLES >= 1");
  end

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_stable;
  logic                   w_sync;
  logic                   w_toggle;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_sw};
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef SW_DEBOUNCE_EN
  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntDone = CntW'(DEBOUNCE_CYCLES - 1);

  logic [CntW-1:0] r_cnt;

  assign w_toggle = (w_sync != r_stable) && (r_cnt == CntDone);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else if (w_sync == r_stable) begin
      r_cnt <= '0;
    end else if (w_toggle) begin
      r_stable <= w_sync;
      r_cnt    <= '0;
    end else if (r_cnt != '1) begin
      // Saturate rather than wrap so a stuck count can never alias to CntDone.
      r_cnt <= r_cnt + CntW'(1);
    end
  end
`else
  assign w_toggle = (w_sync != r_stable);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_stable <= 1'b0;
    end else begin
      r_stable <= w_sync;
    end
  end
`endif

  assign o_stable = r_stable;
  assign o_toggle = w_toggle;

endmodule

// File: rtl/sw_debouncer.sv
// Switch debouncer top: WIDTH independent bit debouncers plus sticky change mask.
// Define SW_DEBOUNCE_EN for full debounce; undefined gives a synchronize-and-register path.
module sw_debouncer
  import sw_pkg::*;
#(
  parameter int unsigned WIDTH           = SW_WIDTH,
  parameter int unsigned SYNC_STAGES     = SW_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_io_sw,
  input  logic             i_chg_clr,
  output logic [WIDTH-1:0] o_sw_stable,
  output logic [WIDTH-1:0] o_chg_mask,
  output logic             o_chg_any
);

  logic [WIDTH-1:0] w_toggle;
  logic [WIDTH-1:0] r_chg_mask;
  logic             r_chg_any;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    sw_debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_sw    (i_io_sw[g]),
      .o_stable(o_sw_stable[g]),
      .o_toggle(w_toggle[g])
    );
  end

  // A toggle on the clearing edge wins over the clear.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_chg_mask <= '0;
      r_chg_any  <= 1'b0;
    end else begin
      r_chg_mask <= (i_chg_clr ? '0 : r_chg_mask) | w_toggle;
      r_chg_any  <= |r_chg_mask;
    end
  end

  assign o_chg_mask = r_chg_mask;
  assign o_chg_any  = r_chg_any;

endmodule
